// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour BCD HH:MM clock with a one-shot, duration-limited alarm.
module alarm_clock #(
  parameter int CYCLES_PER_MIN = 60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] set_Clock,
  input  logic [15:0] set_Alarm,
  input  logic        off_Alarm,
  input  logic [3:0]  dur_Alarm,
  output logic [15:0] Clock,
  output logic        Alarm
);
  localparam int PW = $clog2(CYCLES_PER_MIN + 1);
  logic [PW-1:0] r_pre;
  logic [15:0]   r_clock, r_al_time;
  logic [3:0]    r_dur, r_act_dur, r_ring;
  logic          r_armed, r_alarm;
  logic [15:0]   w_next;
  logic [3:0]    w_dur_eff;
  logic          w_tick, w_load_clk, w_load_al, w_trig;
  function automatic logic valid_time(input logic [15:0] t);
    return t[15:8] <= 8'h23 && t[11:8] <= 4'd9 && t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
  endfunction
  assign w_tick     = r_pre == PW'(CYCLES_PER_MIN - 1);
  assign w_load_clk = set_Clock != 16'h0000 && valid_time(set_Clock);
  assign w_load_al  = set_Alarm[15] && valid_time({1'b0, set_Alarm[14:0]});
  assign w_trig     = r_armed && r_clock == r_al_time && !r_alarm;
  assign w_dur_eff  = r_act_dur == 4'd0 ? 4'd1 : r_act_dur;
  always_comb begin
    w_next = r_clock;
    if (r_clock[3:0] != 4'd9) w_next[3:0] = r_clock[3:0] + 4'd1;
    else begin
      w_next[3:0] = 4'd0;
      if (r_clock[7:4] != 4'd5) w_next[7:4] = r_clock[7:4] + 4'd1;
      else begin
        w_next[7:4] = 4'd0;
        if (r_clock[15:8] == 8'h23) w_next[15:8] = 8'h00;
        else if (r_clock[11:8] == 4'd9) w_next[15:8] = {r_clock[15:12] + 4'd1, 4'd0};
        else w_next[11:8] = r_clock[11:8] + 4'd1;
      end
    end
  end
  // The duration is snapshotted at trigger so a re-arm during a ring cannot shorten or extend it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre     <= '0;
      r_clock   <= 16'h0000;
      r_al_time <= 16'h0000;
      r_dur     <= 4'd0;
      r_act_dur <= 4'd0;
      r_ring    <= 4'd0;
      r_armed   <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_pre <= (w_load_clk || w_tick) ? '0 : r_pre + PW'(1);
      if (w_load_clk) r_clock <= set_Clock;
      else if (w_tick) r_clock <= w_next;
      if (off_Alarm) begin
        r_alarm <= 1'b0;
        r_armed <= 1'b0;
      end else begin
        if (w_load_al) begin
          r_al_time <= {1'b0, set_Alarm[14:0]};
          r_dur     <= dur_Alarm;
        end
        r_armed <= w_load_al ? 1'b1 : (w_trig ? 1'b0 : r_armed);
        if (w_trig) begin
          r_alarm   <= 1'b1;
          r_ring    <= 4'd0;
          r_act_dur <= r_dur;
        end else if (r_alarm && w_tick) begin
          r_ring <= r_ring + 4'd1;
          if (r_ring + 4'd1 >= w_dur_eff) r_alarm <= 1'b0;
        end
      end
    end
  end
  assign Clock = r_clock;
  assign Alarm = r_alarm;
endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: directed scoreboard bench for alarm_clock with a 10-cycle minute.
module tb_alarm_clock;
  localparam int CPM = 10;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] set_Clock = 16'h0000;
  logic [15:0] set_Alarm = 16'h0000;
  logic        off_Alarm = 1'b0;
  logic [3:0]  dur_Alarm = 4'd0;
  logic [15:0] Clock;
  logic        Alarm;
  typedef struct {string tag; logic [15:0] c; logic a;} exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int e = 0;
  alarm_clock #(.CYCLES_PER_MIN(CPM)) dut (
    .clk(clk), .reset(reset), .set_Clock(set_Clock), .set_Alarm(set_Alarm),
    .off_Alarm(off_Alarm), .dur_Alarm(dur_Alarm), .Clock(Clock), .Alarm(Alarm)
  );
  always #5 clk = ~clk;
  task automatic chk();
    exp_t x;
    x = sb.pop_front();
    total++;
    assert (Clock === x.c && Alarm === x.a) else begin
      bad++;
      $error("FAIL %s: got Clock=%h Alarm=%b want Clock=%h Alarm=%b", x.tag, Clock, Alarm, x.c, x.a);
    end
  endtask
  // e counts rising edges since the last clock load; state is sampled on the falling edge.
  task automatic exp_at(input int k, input string tag, input logic [15:0] c, input logic a);
    sb.push_back('{tag, c, a});
    while (e < k) begin
      @(negedge clk);
      e++;
    end
    chk();
  endtask
  task automatic pulse(input logic [15:0] sc, input logic [15:0] sa, input logic off, input logic [3:0] dur);
    set_Clock = sc;
    set_Alarm = sa;
    off_Alarm = off;
    dur_Alarm = dur;
    @(negedge clk);
    set_Clock = 16'h0000;
    set_Alarm = 16'h0000;
    off_Alarm = 1'b0;
    e++;
  endtask
  task automatic load(input logic [15:0] sc, input logic [15:0] sa, input logic [3:0] dur);
    pulse(sc, sa, 1'b0, dur);
    e = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    exp_at(0, "reset_state", 16'h0000, 1'b0);
    reset = 1'b0;
    load(16'h1232, 16'h9308, 4'd8);
    exp_at(0, "load_1232", 16'h1232, 1'b0);
    exp_at(10, "first_tick", 16'h1233, 1'b0);
    exp_at(360, "at_1308", 16'h1308, 1'b0);
    exp_at(361, "ring_on", 16'h1308, 1'b1);
    exp_at(439, "ring_1315", 16'h1315, 1'b1);
    exp_at(440, "ring_off_1316", 16'h1316, 1'b0);
    pulse(16'h0000, 16'h9320, 1'b0, 4'd8);
    exp_at(480, "at_1320", 16'h1320, 1'b0);
    exp_at(481, "rearm_ring", 16'h1320, 1'b1);
    exp_at(485, "ring_1320_held", 16'h1320, 1'b1);
    pulse(16'h0000, 16'h0000, 1'b1, 4'd0);
    exp_at(486, "cancel", 16'h1320, 1'b0);
    exp_at(500, "cancel_hold", 16'h1322, 1'b0);
    exp_at(571, "cancel_past_end", 16'h1329, 1'b0);
    load(16'h1307, 16'h0000, 4'd0);
    exp_at(10, "oneshot_1308", 16'h1308, 1'b0);
    exp_at(11, "no_second_ring", 16'h1308, 1'b0);
    pulse(16'h1275, 16'h0000, 1'b0, 4'd0);
    exp_at(12, "inv_1275", 16'h1308, 1'b0);
    pulse(16'h2400, 16'h0000, 1'b0, 4'd0);
    exp_at(13, "inv_2400", 16'h1308, 1'b0);
    pulse(16'h12a0, 16'h0000, 1'b0, 4'd0);
    exp_at(14, "inv_12a0", 16'h1308, 1'b0);
    exp_at(20, "inv_keeps_pre", 16'h1309, 1'b0);
    load(16'h2358, 16'h0000, 4'd0);
    exp_at(10, "wrap_2359", 16'h2359, 1'b0);
    exp_at(20, "wrap_0000", 16'h0000, 1'b0);
    exp_at(30, "wrap_0001", 16'h0001, 1'b0);
    exp_at(35, "pre_mid", 16'h0001, 1'b0);
    load(16'h1200, 16'h0000, 4'd0);
    exp_at(9, "mid_load_no_tick", 16'h1200, 1'b0);
    exp_at(10, "mid_load_tick", 16'h1201, 1'b0);
    load(16'h0959, 16'h9000, 4'd0);
    exp_at(10, "dur0_at_1000", 16'h1000, 1'b0);
    exp_at(11, "dur0_on", 16'h1000, 1'b1);
    exp_at(19, "dur0_held", 16'h1000, 1'b1);
    exp_at(20, "dur0_off", 16'h1001, 1'b0);
    pulse(16'h0000, 16'h9500, 1'b0, 4'd4);
    load(16'h1500, 16'h0000, 4'd0);
    exp_at(0, "load_eq_alarm", 16'h1500, 1'b0);
    exp_at(1, "load_eq_fires", 16'h1500, 1'b1);
    pulse(16'h0000, 16'h9600, 1'b1, 4'd2);
    exp_at(2, "off_stops", 16'h1500, 1'b0);
    load(16'h1600, 16'h0000, 4'd0);
    exp_at(1, "off_blocks_arm", 16'h1600, 1'b0);
    pulse(16'h0000, 16'h9700, 1'b0, 4'd2);
    load(16'h1700, 16'h0000, 4'd0);
    pulse(16'h0000, 16'h0000, 1'b1, 4'd0);
    exp_at(1, "off_vs_trig", 16'h1700, 1'b0);
    exp_at(3, "off_vs_trig_hold", 16'h1700, 1'b0);
    pulse(16'h0000, 16'h9800, 1'b0, 4'd3);
    load(16'h1800, 16'h0000, 4'd0);
    exp_at(1, "pre_reset_ring", 16'h1800, 1'b1);
    #2 reset = 1'b1;
    #1;
    sb.push_back('{"async_reset", 16'h0000, 1'b0});
    chk();
    #1 reset = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_clock.md
Name: alarm_clock

Overview:
24-hour BCD wall clock (HH:MM) with one programmable one-shot alarm. Runs from a 1 kHz system clock (1 ms period); a prescaler produces one minute tick every CYCLES_PER_MIN cycles. The alarm output stays asserted for a programmable number of minutes, or until it is cancelled. Top-level timekeeping block that drives a display (Clock) and a buzzer (Alarm).

Parameters:
CYCLES_PER_MIN, 60000, clk cycles per minute tick (1 kHz clk gives real time; benches may shrink it).

Ports:
clk  input  1  system clock, rising-edge active, nominal 1 kHz.
reset  input  1  asynchronous, active-high; clears all state.
set_Clock  input  16  time load {HH BCD[15:8], MM BCD[7:0]}; 16'h0000 = no load.
set_Alarm  input  16  bit15 = load/arm strobe; [14:8] hours BCD (bit14 unused, 0); [7:0] minutes BCD.
off_Alarm  input  1  cancel: stops ringing and disarms.
dur_Alarm  input  4  ring duration in minutes, 0..15.
Clock  output  16  current time {HH BCD, MM BCD}.
Alarm  output  1  high while ringing.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: Clock=16'h0000, Alarm=0, armed=0, alarm time=00:00, prescaler=0, ring counter=0.
- All registers update on the clk rising edge. Inputs are sampled at each edge.
- Prescaler counts 0..CYCLES_PER_MIN-1. On the wrap cycle it raises minute_tick for one cycle.
- On minute_tick, Clock advances by one minute in BCD:
  - MM 59 -> 00 with an hour carry.
  - HH 23:59 -> 00:00.
  - Digits stay valid BCD at all times.
- Clock load:
  - Triggered when set_Clock != 0 and the value is valid (HH<=23, MM<=59, all nibbles <=9).
  - Clock takes the value at that edge and the prescaler clears to 0.
  - The next minute tick comes CYCLES_PER_MIN cycles later.
  - Invalid nonzero values are ignored. Load takes priority over minute_tick in the same cycle.
- Alarm load:
  - Triggered when set_Alarm[15]=1 and [14:0] holds a valid time.
  - Latches the time and dur_Alarm, and sets armed=1. Invalid values are ignored.
  - A load while ringing does not stop the current ring.
- Trigger:
  - When armed=1, Clock == alarm time, and Alarm=0, the next edge sets Alarm=1, clears armed (one-shot), and clears the ring counter.
  - This also fires if set_Clock loads a time equal to the alarm time.
- Ringing:
  - The ring counter increments on each minute_tick.
  - When it reaches the latched duration, Alarm drops at that edge. The ring ends exactly when Clock reaches alarm time + dur.
  - A latched duration of 0 is treated as 1 minute.
- off_Alarm=1:
  - Alarm=0 and armed=0 at the next edge.
  - It overrides a trigger and an alarm load in the same cycle.
- Clock loads during ringing do not affect the ring counter.
- Asserting reset mid-operation immediately returns every register to its reset value.

Test Plan:
- Reset: pulse reset asynchronously between edges -> Clock=0000 and Alarm=0 at once, with no clk edge needed.
- Basic ring: load set_Clock=16'h1232, set_Alarm=16'h9308, dur_Alarm=8 -> Alarm rises one cycle after Clock=1308 (36 minute ticks after the load) and falls at Clock=1316.
- Re-arm: after the first ring ends, load set_Alarm=16'h9320 -> Alarm rises at 1320 and falls at 1328. With no re-arm, no second ring at 1308 on the next day.
- Cancel: pulse off_Alarm for one cycle during the 1320 ring -> Alarm=0 on the next edge and stays 0. Armed is cleared.
- Wrap: load 16'h2358 and run 3 minute ticks -> Clock steps 2359, 0000, 0001.
- Edge cases:
  - Load set_Clock=16'h1275 -> ignored, Clock unchanged.
  - dur_Alarm=0 -> rings for exactly 1 minute.
  - A set_Clock load mid-minute -> next tick comes exactly CYCLES_PER_MIN cycles after the load.
